// File: rtl/alu_pkg.sv
// Shared encodings for the ALU sequencer: op codes, FSM states and strobe indices.
// Each strobe index is the bit position of that micro-op in the sequencer's strobe vector.
package alu_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [3:0] {
      IDLE, LD_A, LD_M, LD_Q, EXEC, CLR, TEST, ADD,
      SUB, SHR, SHL, CHK, RST, SET, OUT_A, OUT_Q
   } state_t;

   localparam int NUM_UOP  = 11;
   localparam int UOP_CLR  = 0;   // clear A and Q[-1]
   localparam int UOP_LDQ  = 1;
   localparam int UOP_LDM  = 2;
   localparam int UOP_ADD  = 3;
   localparam int UOP_SUB  = 4;
   localparam int UOP_OUTA = 5;
   localparam int UOP_OUTQ = 6;
   localparam int UOP_LDA  = 7;
   localparam int UOP_SHL  = 8;
   localparam int UOP_SETQ = 9;
   localparam int UOP_SHR  = 10;

endpackage

// File: rtl/alu_iter_cnt.sv
// Iteration counter for the MUL/DIV loops: clear, increment, and a flag that is
// high in the step whose increment brings the count to W.
module alu_iter_cnt #(
   parameter int W  = 64,
   parameter int CW = $clog2(W) + 1
) (
   input  logic clk,
   input  logic rst_b,
   input  logic clr,
   input  logic inc,
   output logic tc
);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;

   assign cnt_nxt = cnt + CW'(1);
   assign tc      = inc && (cnt_nxt == CW'(W));

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt_nxt;
      end
   end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Micro-program sequencer for the ALU: ADD/SUB single step, Booth radix-2 MUL,
// restoring DIV. Strobes are decoded from the state register and latched op only.
module alu_ctrl_seq
   import alu_pkg::*;
#(
   parameter int W  = 64,
   parameter int CW = $clog2(W) + 1
) (
   input  logic       clk,
   input  logic       rst_b,
   input  logic       start,
   input  logic [1:0] op,
   input  logic       q0,
   input  logic       q_m1,
   input  logic       a_msb,
   output logic       c0,
   output logic       c1,
   output logic       c2,
   output logic       c3,
   output logic       c4,
   output logic       c5,
   output logic       c6,
   output logic       c7,
   output logic       c8,
   output logic       c9,
   output logic       c10,
   output logic       busy,
   output logic       done,
   output state_t     dbg_state
);

   state_t             state;
   state_t             state_nxt;
   logic [1:0]         op_q;
   logic [NUM_UOP-1:0] uop;
   logic               cnt_clr;
   logic               cnt_inc;
   logic               cnt_tc;

   alu_iter_cnt #(.W(W), .CW(CW)) u_iter_cnt (
      .clk   (clk),
      .rst_b (rst_b),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .tc    (cnt_tc)
   );

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state <= IDLE;
         op_q  <= OP_ADD;
      end else begin
         state <= state_nxt;
         if (state == IDLE && start) op_q <= op;
      end
   end

   always_comb begin
      state_nxt = state;
      uop       = '0;
      busy      = 1'b1;
      done      = 1'b0;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      case (state)
         IDLE: begin
            busy    = 1'b0;
            cnt_clr = 1'b1;
            if (start) state_nxt = (op == OP_ADD || op == OP_SUB) ? LD_A : CLR;
         end
         LD_A: begin
            uop[UOP_LDA] = 1'b1;
            state_nxt    = LD_M;
         end
         LD_M: begin
            uop[UOP_LDM] = 1'b1;
            if (op_q == OP_MUL)      state_nxt = TEST;
            else if (op_q == OP_DIV) state_nxt = SHL;
            else                     state_nxt = EXEC;
         end
         EXEC: begin
            if (op_q == OP_SUB) uop[UOP_SUB] = 1'b1;
            else                uop[UOP_ADD] = 1'b1;
            state_nxt = OUT_A;
         end
         CLR: begin
            uop[UOP_CLR] = 1'b1;
            cnt_clr      = 1'b1;
            state_nxt    = LD_Q;
         end
         LD_Q: begin
            uop[UOP_LDQ] = 1'b1;
            state_nxt    = LD_M;
         end
         // Booth decision is taken one cycle after the shift so q0/q_m1 have settled
         TEST: begin
            case ({q0, q_m1})
               2'b10:   state_nxt = SUB;
               2'b01:   state_nxt = ADD;
               default: state_nxt = SHR;
            endcase
         end
         ADD: begin
            uop[UOP_ADD] = 1'b1;
            state_nxt    = SHR;
         end
         SUB: begin
            uop[UOP_SUB] = 1'b1;
            state_nxt    = (op_q == OP_MUL) ? SHR : CHK;
         end
         SHR: begin
            uop[UOP_SHR] = 1'b1;
            cnt_inc      = 1'b1;
            state_nxt    = cnt_tc ? OUT_A : TEST;
         end
         SHL: begin
            uop[UOP_SHL] = 1'b1;
            state_nxt    = SUB;
         end
         CHK: begin
            state_nxt = a_msb ? RST : SET;
         end
         RST, SET: begin
            if (state == RST) uop[UOP_ADD]  = 1'b1;
            else              uop[UOP_SETQ] = 1'b1;
            cnt_inc   = 1'b1;
            state_nxt = cnt_tc ? OUT_Q : SHL;
         end
         // MUL emits the high word first; DIV emits the remainder last
         OUT_A: begin
            uop[UOP_OUTA] = 1'b1;
            if (op_q == OP_MUL) begin
               state_nxt = OUT_Q;
            end else begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         OUT_Q: begin
            uop[UOP_OUTQ] = 1'b1;
            if (op_q == OP_DIV) begin
               state_nxt = OUT_A;
            end else begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign c0        = uop[UOP_CLR];
   assign c1        = uop[UOP_LDQ];
   assign c2        = uop[UOP_LDM];
   assign c3        = uop[UOP_ADD];
   assign c4        = uop[UOP_SUB];
   assign c5        = uop[UOP_OUTA];
   assign c6        = uop[UOP_OUTQ];
   assign c7        = uop[UOP_LDA];
   assign c8        = uop[UOP_SHL];
   assign c9        = uop[UOP_SETQ];
   assign c10       = uop[UOP_SHR];
   assign dbg_state = state;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq at W=8: behavioural A/M/Q registers driven by the strobes,
// results checked against plain integer arithmetic and the documented latencies.
module tb_alu_ctrl_seq;
   import alu_pkg::*;

   localparam int W = 8;

   logic       clk;
   logic       rst_b;
   logic       start;
   logic [1:0] op;
   logic       q0, q_m1, a_msb;
   logic       c0, c1, c2, c3, c4, c5, c6, c7, c8, c9, c10;
   logic       busy, done;
   state_t     dbg_state;

   logic [W:0]   a_reg;
   logic [W-1:0] m_reg, q_reg;
   logic         qm1;
   logic [W-1:0] inbus, outbus;
   logic [W:0]   m_ext;
   logic         cur_div;
   logic [10:0]  cvec;

   int n_cmp = 0;
   int n_err = 0;
   logic [W-1:0] exp_q[$];

   alu_ctrl_seq #(.W(W)) dut (
      .clk(clk), .rst_b(rst_b), .start(start), .op(op),
      .q0(q0), .q_m1(q_m1), .a_msb(a_msb),
      .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6),
      .c7(c7), .c8(c8), .c9(c9), .c10(c10),
      .busy(busy), .done(done), .dbg_state(dbg_state)
   );

   // clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Datapath registers; A carries one guard bit so its sign is exact in both algorithms
   assign m_ext  = cur_div ? {1'b0, m_reg} : {m_reg[W-1], m_reg};
   assign q0     = q_reg[0];
   assign q_m1   = qm1;
   assign a_msb  = a_reg[W];
   assign outbus = c5 ? a_reg[W-1:0] : (c6 ? q_reg : '0);
   assign cvec   = {c10, c9, c8, c7, c6, c5, c4, c3, c2, c1, c0};

   always @(posedge clk) begin
      if (c0) begin
         a_reg <= '0;
         qm1   <= 1'b0;
      end
      if (c1)  q_reg <= inbus;
      if (c2)  m_reg <= inbus;
      if (c3)  a_reg <= a_reg + m_ext;
      if (c4)  a_reg <= a_reg - m_ext;
      if (c7)  a_reg <= {1'b0, inbus};
      if (c8)  {a_reg, q_reg} <= {a_reg[W-1:0], q_reg, 1'b0};
      if (c9)  q_reg[0] <= 1'b1;
      if (c10) {a_reg, q_reg, qm1} <= {a_reg[W], a_reg, q_reg};
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int booth_steps(input logic [W-1:0] x);
      int   k = 0;
      logic prev = 1'b0;
      for (int i = 0; i < W; i++) begin
         if (x[i] != prev) k++;
         prev = x[i];
      end
      return k;
   endfunction

   // Reference: expected output words in emission order, and cycles from acceptance to done
   task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int lat);
      int p;
      logic [2*W-1:0] pw;
      exp_q.delete();
      case (o)
         OP_ADD: begin exp_q.push_back(W'(x + y)); lat = 4; end
         OP_SUB: begin exp_q.push_back(W'(x - y)); lat = 4; end
         OP_MUL: begin
            p  = $signed(x) * $signed(y);
            pw = p[2*W-1:0];
            exp_q.push_back(pw[2*W-1:W]);
            exp_q.push_back(pw[W-1:0]);
            lat = 3 + 2 * W + booth_steps(x) + 2;
         end
         default: begin
            if (y == 0) begin
               exp_q.push_back({W{1'b1}});
               exp_q.push_back(x);
            end else begin
               exp_q.push_back(W'(x / y));
               exp_q.push_back(W'(x % y));
            end
            lat = 3 + 4 * W + 2;
         end
      endcase
   endtask

   // driver + scoreboard for one operation
   task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit hold);
      int  cyc = 0;
      int  lat;
      int  done_cyc = -1;
      int  multi = 0;
      int  idle_seen = 0;
      int  idx;
      bit  addsub;
      logic [W-1:0] got_q[$];
      addsub = (o == OP_ADD || o == OP_SUB);
      model(o, x, y, lat);
      @(negedge clk);
      check("idle_gap", {31'b0, busy}, 0);
      cur_div = (o == OP_DIV);
      start   = 1'b1;
      op      = o;
      inbus   = W'($urandom);
      while (done_cyc < 0 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (!hold) start = 1'b0;
         op = 2'($urandom_range(0, 3));
         if (cyc == 1)      inbus = x;
         else if (cyc == 2) inbus = addsub ? y : x;
         else if (cyc == 3) inbus = addsub ? W'($urandom) : y;
         else               inbus = W'($urandom);
         if ($countones(cvec) > 1) multi++;
         if (!busy) idle_seen++;
         if (c5 || c6) got_q.push_back(outbus);
         if (addsub && cyc <= 4) begin
            idx = -1;
            for (int i = 0; i < 11; i++) if (cvec[i]) idx = i;
            case (cyc)
               1: check("as_strobe1", idx, 7);
               2: check("as_strobe2", idx, 2);
               3: check("as_strobe3", idx, (o == OP_SUB) ? 4 : 3);
               default: check("as_strobe4", idx, 5);
            endcase
         end
         if (done) done_cyc = cyc;
      end
      check("done_cycle", done_cyc, lat);
      check("onehot", multi, 0);
      check("busy_held", idle_seen, 0);
      check("n_words", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("word%0d_op%0d_%0h_%0h", i, o, x, y), got_q[i], exp_q[i]);
   endtask

   initial begin
      rst_b   = 1'b0;
      start   = 1'b0;
      op      = OP_ADD;
      inbus   = '0;
      cur_div = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_strobes", {21'b0, cvec}, 0);
      check("rst_busy", {31'b0, busy}, 0);
      check("rst_done", {31'b0, done}, 0);
      check("rst_state", {28'b0, dbg_state}, {28'b0, IDLE});
      rst_b = 1'b1;

      // reset in the middle of a MUL
      @(negedge clk);
      start = 1'b1;
      op    = OP_MUL;
      repeat (6) begin
         @(negedge clk);
         start = 1'b0;
         inbus = 8'd3;
      end
      check("mid_mul_busy", {31'b0, busy}, 1);
      #2 rst_b = 1'b0;
      #1;
      check("abort_strobes", {21'b0, cvec}, 0);
      check("abort_busy", {31'b0, busy}, 0);
      check("abort_state", {28'b0, dbg_state}, {28'b0, IDLE});
      @(negedge clk);
      rst_b = 1'b1;

      // directed cases
      run_op(OP_MUL, 8'd3, 8'd5, 1'b0);
      run_op(OP_ADD, 8'd200, 8'd100, 1'b0);
      run_op(OP_SUB, 8'd5, 8'd9, 1'b0);
      run_op(OP_MUL, 8'd5, 8'd3, 1'b0);
      run_op(OP_MUL, 8'hFD, 8'hFF, 1'b0);
      run_op(OP_MUL, 8'd127, 8'h80, 1'b0);
      run_op(OP_DIV, 8'd100, 8'd7, 1'b0);
      run_op(OP_DIV, 8'd9, 8'd0, 1'b0);

      // start held high with op churning while busy
      run_op(OP_DIV, 8'd200, 8'd13, 1'b1);
      run_op(OP_SUB, 8'd17, 8'd30, 1'b1);
      run_op(OP_MUL, 8'h81, 8'h7F, 1'b1);
      start = 1'b0;

      // randomized mix
      for (int n = 0; n < 40; n++) begin
         logic [1:0]   ro;
         logic [W-1:0] rx, ry;
         ro = 2'($urandom_range(0, 3));
         rx = W'($urandom);
         ry = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
         run_op(ro, rx, ry, $urandom_range(0, 3) == 0);
      end
      start = 1'b0;
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
